sobel_frame_sequencer: RTL

//  Frame-level controller for the edge pipeline. It drives one shared conv_unit

---
 rtl/sobel_frame_sequencer_pkg.sv | 41 ++++
 rtl/sobel_frame_sequencer_if.sv | 17 +
 rtl/sobel_frame_sequencer_edge_mag_unit.sv | 25 ++
 rtl/sobel_frame_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sobel_frame_sequencer_pkg.sv
// Shared types and Sobel kernel constants for the edge pipeline controller.
package edge_pkg;

  localparam int EDGE_DW   = 16;
  localparam int EDGE_FRAC = 8;

  typedef enum logic [2:0] {
    IDLE,
    RUN_GX,
    REL_GX,
    RUN_GY,
    REL_GY,
    COMBINE,
    FINISH
  } state_t;

  typedef logic signed [0:2][0:2][EDGE_DW-1:0] kernel_t;

  // Integer Sobel tap; Gy is the transpose of Gx.
  function automatic int sobel_tap(input logic is_gy, input int r, input int c);
    int a;
    int b;
    a = is_gy ? c : r;
    b = is_gy ? r : c;
    return (b - 1) * ((a == 1) ? 2 : 1);
  endfunction

  function automatic kernel_t sobel_kernel(input logic is_gy);
    kernel_t k;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        k[r][c] = EDGE_DW'(sobel_tap(is_gy, r, c) * (2 ** EDGE_FRAC));
      end
    end
    return k;
  endfunction

  localparam kernel_t SOBEL_GX = sobel_kernel(1'b0);
  localparam kernel_t SOBEL_GY = sobel_kernel(1'b1);

endpackage

// File: rtl/sobel_frame_sequencer_if.sv
// Enable/done/kernel/result bundle between the sequencer and the shared conv_unit.
// Handshake: master raises conv_enable with conv_kernel already stable; slave raises
// conv_done with conv_result valid; master drops enable, slave then drops done.
interface sobel_frame_sequencer_if #(
  parameter int IMAGE_HEIGHT = 5,
  parameter int IMAGE_WIDTH  = 5,
  parameter int KERNEL_SIZE  = 3,
  parameter int DATA_WIDTH   = 16
);
  logic                                                          conv_enable;
  logic                                                          conv_done;
  logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DATA_WIDTH-1:0]       conv_kernel;
  logic [0:IMAGE_HEIGHT-1][0:IMAGE_WIDTH-1][DATA_WIDTH-1:0]      conv_result;

  modport master (output conv_enable, output conv_kernel, input conv_done, input conv_result);
  modport slave  (input conv_enable, input conv_kernel, output conv_done, output conv_result);
endinterface

// File: rtl/sobel_frame_sequencer_edge_mag_unit.sv
// Per-pixel |gx|+|gy| with saturation to the largest positive word, and threshold compare.
module edge_mag_unit #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] gx,
  input  logic [DATA_WIDTH-1:0] gy,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic [DATA_WIDTH-1:0] magnitude,
  output logic                  edge_bit
);
  localparam logic [DATA_WIDTH+1:0] SAT_MAX = {3'b000, {(DATA_WIDTH-1){1'b1}}};

  logic [DATA_WIDTH:0]   abs_gx;
  logic [DATA_WIDTH:0]   abs_gy;
  logic [DATA_WIDTH+1:0] sum;

  // One extra bit so the most negative input negates without wrapping.
  always_comb begin
    abs_gx    = gx[DATA_WIDTH-1] ? (~{gx[DATA_WIDTH-1], gx} + (DATA_WIDTH+1)'(1)) : {1'b0, gx};
    abs_gy    = gy[DATA_WIDTH-1] ? (~{gy[DATA_WIDTH-1], gy} + (DATA_WIDTH+1)'(1)) : {1'b0, gy};
    sum       = {1'b0, abs_gx} + {1'b0, abs_gy};
    magnitude = (sum > SAT_MAX) ? SAT_MAX[DATA_WIDTH-1:0] : sum[DATA_WIDTH-1:0];
    edge_bit  = magnitude > threshold;
  end
endmodule

// File: rtl/sobel_frame_sequencer.sv
// Runs the shared conv_unit with Gx then Gy, buffers both gradients, then builds the
// saturated magnitude and thresholded edge map one pixel per cycle in raster order.
module sobel_frame_sequencer
  import edge_pkg::*;
#(
  parameter int IMAGE_HEIGHT   = 5,
  parameter int IMAGE_WIDTH    = 5,
  parameter int KERNEL_SIZE    = 3,
  parameter int DATA_WIDTH     = 16,
  parameter int FRAC_BITS      = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  error,
  sobel_frame_sequencer_if.master conv,
  output logic [0:IMAGE_HEIGHT-1][0:IMAGE_WIDTH-1][DATA_WIDTH-1:0] magnitude,
  output logic [0:IMAGE_HEIGHT-1][0:IMAGE_WIDTH-1]                 edge_map,
  output state_t                dbg_state
);
  localparam int H     = IMAGE_HEIGHT;
  localparam int W     = IMAGE_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ROW_W = (H > 1) ? $clog2(H) : 1;
  localparam int COL_W = (W > 1) ? $clog2(W) : 1;

  typedef logic [0:H-1][0:W-1][DW-1:0]                   frame_t;
  typedef logic [0:H-1][0:W-1]                           map_t;
  typedef logic [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1][DW-1:0] kern_t;

  generate
    if (KERNEL_SIZE != 3) begin : g_bad_kernel_size
      $error("sobel_frame_sequencer: KERNEL_SIZE must be 3");
    end
  endgenerate

  function automatic kern_t build_kernel(input logic is_gy);
    kern_t k;
    k = '0;
    for (int r = 0; r < KERNEL_SIZE; r++) begin
      for (int c = 0; c < KERNEL_SIZE; c++) begin
        k[r][c] = DW'(sobel_tap(is_gy, r, c) * (2 ** FRAC_BITS));
      end
    end
    return k;
  endfunction

  localparam kern_t GX_KERNEL = build_kernel(1'b0);
  localparam kern_t GY_KERNEL = build_kernel(1'b1);

  state_t            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              seen_low_q, seen_low_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [DW-1:0]     thr_q, thr_d;
  kern_t             kernel_q, kernel_d;
  logic              error_q, error_d;
  frame_t            gx_q, gx_d;
  frame_t            gy_q, gy_d;
  frame_t            mag_q, mag_d;
  map_t              edge_q, edge_d;

  logic              wd_expired;
  logic [DW-1:0]     pix_mag;
  logic              pix_edge;

  edge_mag_unit #(.DATA_WIDTH(DW)) u_mag (
    .gx        (gx_q[row_q][col_q]),
    .gy        (gy_q[row_q][col_q]),
    .threshold (thr_q),
    .magnitude (pix_mag),
    .edge_bit  (pix_edge)
  );

  assign wd_expired = (wd_q >= WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    seen_low_d = seen_low_q;
    row_d      = row_q;
    col_d      = col_q;
    thr_d      = thr_q;
    kernel_d   = kernel_q;
    error_d    = error_q;
    gx_d       = gx_q;
    gy_d       = gy_q;
    mag_d      = mag_q;
    edge_d     = edge_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          thr_d      = threshold;
          kernel_d   = GX_KERNEL;
          error_d    = 1'b0;
          wd_d       = '0;
          // A done already high at launch is a leftover and must drop before capture.
          seen_low_d = ~conv.conv_done;
          state_d    = RUN_GX;
        end
      end

      RUN_GX, RUN_GY: begin
        wd_d = wd_q + WD_W'(1);
        if (!conv.conv_done) begin
          seen_low_d = 1'b1;
        end
        if (conv.conv_done && seen_low_q) begin
          if (state_q == RUN_GX) begin
            gx_d     = conv.conv_result;
            // Gy goes out while enable is low so it is settled before the next pass.
            kernel_d = GY_KERNEL;
            state_d  = REL_GX;
          end else begin
            gy_d     = conv.conv_result;
            state_d  = REL_GY;
          end
        end else if (wd_expired) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end

      REL_GX, REL_GY: begin
        wd_d = wd_q + WD_W'(1);
        if (!conv.conv_done) begin
          if (state_q == REL_GX) begin
            wd_d       = '0;
            seen_low_d = 1'b1;
            state_d    = RUN_GY;
          end else begin
            row_d   = '0;
            col_d   = '0;
            state_d = COMBINE;
          end
        end else if (wd_expired) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end

      COMBINE: begin
        mag_d[row_q][col_q]  = pix_mag;
        edge_d[row_q][col_q] = pix_edge;
        if (col_q == COL_W'(W - 1)) begin
          col_d = '0;
          if (row_q == ROW_W'(H - 1)) begin
            state_d = FINISH;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          col_d = col_q + COL_W'(1);
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wd_q       <= '0;
      seen_low_q <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      thr_q      <= '0;
      kernel_q   <= '0;
      error_q    <= 1'b0;
      gx_q       <= '0;
      gy_q       <= '0;
      mag_q      <= '0;
      edge_q     <= '0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      seen_low_q <= seen_low_d;
      row_q      <= row_d;
      col_q      <= col_d;
      thr_q      <= thr_d;
      kernel_q   <= kernel_d;
      error_q    <= error_d;
      gx_q       <= gx_d;
      gy_q       <= gy_d;
      mag_q      <= mag_d;
      edge_q     <= edge_d;
    end
  end

  assign conv.conv_enable = (state_q == RUN_GX) || (state_q == RUN_GY);
  assign conv.conv_kernel = kernel_q;
  assign busy             = (state_q != IDLE) && (state_q != FINISH);
  assign frame_done       = (state_q == FINISH);
  assign error            = error_q;
  assign magnitude        = mag_q;
  assign edge_map         = edge_q;
  assign dbg_state        = state_q;

endmodule
